// File: rtl/core_inst_seq_pkg.sv
// Shared constants for the core instruction sequencer: array geometry,
// inst word field map, idle word and FSM state encoding.
package core_inst_pkg;

  localparam int ROW       = 8;
  localparam int COL       = 8;
  localparam int LEN_KIJ   = 9;
  localparam int K_W       = 3;
  localparam int IN_W      = 6;
  localparam int LEN_NIJ   = IN_W * IN_W;
  localparam int O_W       = 4;
  localparam int LEN_ONIJ  = O_W * O_W;
  localparam int GAP       = 10;
  localparam int ADDR_W    = 11;
  localparam int INST_W    = 47;
  localparam int ONIJ_W    = $clog2(LEN_ONIJ);
  localparam int ACC_STEPS = K_W * K_W + 2;

  localparam int B_CEN_XMEM = 46;
  localparam int B_WEN_XMEM = 45;
  localparam int AX_HI      = 44;
  localparam int AX_LO      = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_PMEM = 32;
  localparam int B_WEN_PMEM = 31;
  localparam int AP_HI      = 30;
  localparam int AP_LO      = 20;
  localparam int B_CEN_WMEM = 19;
  localparam int B_WEN_WMEM = 18;
  localparam int AW_HI      = 17;
  localparam int AW_LO      = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXECUTE  = 1;
  localparam int B_LOAD     = 0;

  // All SRAMs deselected and in read mode, every strobe low.
  localparam logic [INST_W-1:0] IDLE_INST = INST_W'(
      (64'd1 << B_CEN_XMEM) | (64'd1 << B_WEN_XMEM) |
      (64'd1 << B_CEN_PMEM) | (64'd1 << B_WEN_PMEM) |
      (64'd1 << B_CEN_WMEM) | (64'd1 << B_WEN_WMEM));

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_L0,
    S_W_LOAD,
    S_GAP,
    S_X_STREAM,
    S_DRAIN,
    S_OFIFO_RD,
    S_ACC,
    S_DONE
  } state_t;

endpackage

// File: rtl/core_inst_seq_if.sv
// Sequencer/core bundle: start and OFIFO status in, instruction word and
// progress flags out. master = sequencer, slave = core side.
interface core_inst_seq_if;
  import core_inst_pkg::*;

  logic                start;
  logic                ofifo_valid;
  logic [INST_W-1:0]   inst;
  logic                busy;
  logic                onij_done;
  logic [ONIJ_W-1:0]   onij_idx;
  logic                done;

  modport master (input start, ofifo_valid,
                  output inst, busy, onij_done, onij_idx, done);
  modport slave  (output start, ofifo_valid,
                  input inst, busy, onij_done, onij_idx, done);
endinterface

// File: rtl/core_inst_seq_acc_addr_gen.sv
// Psum read-out walker: steps kernel tap j within each output o and forms
// the psum SRAM address of that tap.
module acc_addr_gen
  import core_inst_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ONIJ_W-1:0] o,
  output logic [3:0]        j,
  output logic [ADDR_W-1:0] addr,
  output logic              out_done,
  output logic              last
);

  localparam logic [3:0]        J_END = 4'(ACC_STEPS - 1);
  localparam logic [ONIJ_W-1:0] O_END = ONIJ_W'(LEN_ONIJ - 1);
  localparam logic [ADDR_W-1:0] A_NIJ = ADDR_W'(LEN_NIJ);
  localparam logic [ADDR_W-1:0] A_KW  = ADDR_W'(K_W);
  localparam logic [ADDR_W-1:0] A_IW  = ADDR_W'(IN_W);
  localparam logic [ADDR_W-1:0] A_OW  = ADDR_W'(O_W);

  logic [ADDR_W-1:0] o_a, j_a;

  assign o_a = ADDR_W'(o);
  assign j_a = ADDR_W'(j);

  // Tap j of output (orow, ocol) lives in kij plane j at input pixel
  // (orow + j/k_w, ocol + j%k_w).
  assign addr = j_a * A_NIJ + (o_a / A_OW + j_a / A_KW) * A_IW
              + o_a % A_OW + j_a % A_KW;

  assign out_done = en && (j == J_END);
  assign last     = out_done && (o == O_END);

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      o <= '0;
      j <= '0;
    end else if (j == J_END) begin
      j <= '0;
      o <= o + 1'b1;
    end else begin
      j <= j + 1'b1;
    end
  end

endmodule

// File: rtl/core_inst_seq.sv
// Autonomous instruction sequencer: per kernel position fetches weights,
// streams activations, drains OFIFO to psum, then runs psum accumulation.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_W_L0     | weight SRAM read into L0, col cycles
// S_W_LOAD   | L0 -> PE weight load, row+col-1 cycles
// S_GAP      | settle, idle word
// S_X_STREAM | activation SRAM read, L0 read + execute
// S_DRAIN    | pipeline drain, row+col-1 cycles
// S_OFIFO_RD | OFIFO -> psum write, stalls while OFIFO empty
// S_ACC      | psum accumulation read-out, 11 cycles per output
// S_DONE     | one-cycle done pulse
module core_inst_seq
  import core_inst_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  core_inst_seq_if.master bus
);

  localparam int T_W   = $clog2(LEN_NIJ + 1);
  localparam int KIJ_W = $clog2(LEN_KIJ);

  localparam logic [T_W-1:0]   T_WL0_END  = T_W'(COL - 1);
  localparam logic [T_W-1:0]   T_PIPE_END = T_W'(ROW + COL - 2);
  localparam logic [T_W-1:0]   T_GAP_END  = T_W'(GAP - 1);
  localparam logic [T_W-1:0]   T_NIJ_END  = T_W'(LEN_NIJ - 1);
  localparam logic [KIJ_W-1:0] K_END      = KIJ_W'(LEN_KIJ - 1);
  localparam logic [3:0]       J_TAPS     = 4'(K_W * K_W);

  state_t              state;
  logic [T_W-1:0]      t;
  logic [KIJ_W-1:0]    k;
  logic [INST_W-1:0]   inst_q, inst_nxt;
  logic                busy_q, done_q, onij_done_q;
  logic [ONIJ_W-1:0]   onij_idx_q;
  logic                acc_en, acc_out_done, acc_last;
  logic [3:0]          acc_j;
  logic [ONIJ_W-1:0]   acc_o;
  logic [ADDR_W-1:0]   acc_addr, wmem_addr, pmem_wr_addr;

  assign acc_en       = (state == S_ACC);
  assign wmem_addr    = ADDR_W'(k) * ADDR_W'(COL) + ADDR_W'(t);
  assign pmem_wr_addr = ADDR_W'(k) * ADDR_W'(LEN_NIJ) + ADDR_W'(t);

  acc_addr_gen u_acc_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (acc_en),
    .o        (acc_o),
    .j        (acc_j),
    .addr     (acc_addr),
    .out_done (acc_out_done),
    .last     (acc_last)
  );

  always_comb begin
    inst_nxt = IDLE_INST;
    // SRAM data arrives one cycle after the read, so L0 writes trail reads.
    inst_nxt[B_L0_WR] = ~inst_q[B_CEN_WMEM] | ~inst_q[B_CEN_XMEM];
    case (state)
      S_W_L0: begin
        inst_nxt[B_CEN_WMEM]  = 1'b0;
        inst_nxt[AW_HI:AW_LO] = wmem_addr;
      end
      S_W_LOAD: begin
        inst_nxt[B_L0_RD] = 1'b1;
        inst_nxt[B_LOAD]  = 1'b1;
      end
      S_X_STREAM: begin
        inst_nxt[B_CEN_XMEM]  = 1'b0;
        inst_nxt[AX_HI:AX_LO] = ADDR_W'(t);
        inst_nxt[B_L0_RD]     = (t != '0);
        inst_nxt[B_EXECUTE]   = (t != '0);
      end
      S_DRAIN: begin
        inst_nxt[B_L0_RD]   = 1'b1;
        inst_nxt[B_EXECUTE] = 1'b1;
      end
      S_OFIFO_RD: begin
        if (bus.ofifo_valid) begin
          inst_nxt[B_OFIFO_RD]  = 1'b1;
          inst_nxt[B_CEN_PMEM]  = 1'b0;
          inst_nxt[B_WEN_PMEM]  = 1'b0;
          inst_nxt[AP_HI:AP_LO] = pmem_wr_addr;
        end
      end
      S_ACC: begin
        if (acc_j < J_TAPS) begin
          inst_nxt[B_CEN_PMEM]  = 1'b0;
          inst_nxt[AP_HI:AP_LO] = acc_addr;
          inst_nxt[B_ACC]       = (acc_j != '0);
        end else if (acc_j == J_TAPS) begin
          inst_nxt[B_ACC] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      t           <= '0;
      k           <= '0;
      inst_q      <= IDLE_INST;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      onij_done_q <= 1'b0;
      onij_idx_q  <= '0;
    end else begin
      inst_q      <= inst_nxt;
      busy_q      <= (state != S_IDLE);
      done_q      <= (state == S_DONE);
      onij_done_q <= acc_out_done;
      if (acc_out_done) onij_idx_q <= acc_o;
      case (state)
        S_IDLE: if (bus.start) begin
          state <= S_W_L0;
          k     <= '0;
          t     <= '0;
        end
        S_W_L0: if (t == T_WL0_END) begin
          state <= S_W_LOAD;
          t     <= '0;
        end else t <= t + 1'b1;
        S_W_LOAD: if (t == T_PIPE_END) begin
          state <= S_GAP;
          t     <= '0;
        end else t <= t + 1'b1;
        S_GAP: if (t == T_GAP_END) begin
          state <= S_X_STREAM;
          t     <= '0;
        end else t <= t + 1'b1;
        S_X_STREAM: if (t == T_NIJ_END) begin
          state <= S_DRAIN;
          t     <= '0;
        end else t <= t + 1'b1;
        S_DRAIN: if (t == T_PIPE_END) begin
          state <= S_OFIFO_RD;
          t     <= '0;
        end else t <= t + 1'b1;
        S_OFIFO_RD: if (bus.ofifo_valid) begin
          if (t == T_NIJ_END) begin
            t <= '0;
            if (k == K_END) state <= S_ACC;
            else begin
              k     <= k + 1'b1;
              state <= S_W_L0;
            end
          end else t <= t + 1'b1;
        end
        S_ACC:   if (acc_last) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.inst      = inst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.onij_done = onij_done_q;
  assign bus.onij_idx  = onij_idx_q;

endmodule

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Autonomous instruction sequencer that drives the 47-bit inst bus of core, replacing hand-scripted stimulus.
- On start, for each of len_kij kernel positions it runs: weight fetch to L0, weight load to PEs, settle gap, activation stream/execute, drain, OFIFO-to-psum write. It then runs the psum accumulation read-out sequence for all len_onij outputs.
- Activations (xmem 0..len_nij-1) and weights (wmem kij*col+r) are preloaded before start.

Parameters:
- row, 8, PE array rows (ic)
- col, 8, PE array columns (oc)
- len_kij, 9, kernel positions (k_w*k_w)
- k_w, 3, kernel width
- in_w, 6, input feature-map width; len_nij = in_w*in_w
- o_w, 4, output width; len_onij = o_w*o_w
- gap, 10, idle cycles after weight load
- addr_w, 11, SRAM address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begins sequence when idle
- ofifo_valid  in  1  core OFIFO holds a full row
- inst  out  47  registered instruction word to core
- busy  out  1  sequence in progress
- onij_done  out  1  pulse: one output's accumulation issued
- onij_idx  out  $clog2(len_onij)  index of that output
- done  out  1  one-cycle pulse at sequence end

Behaviour:
- inst field map: [46] CEN_xmem, [45] WEN_xmem, [44:34] A_xmem, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_wmem, [18] WEN_wmem, [17:7] A_wmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- IDLE word: all CEN/WEN=1, all else 0. This is also the reset value of inst. busy, done, onij_done and onij_idx reset to 0.
- inst, busy, onij_* and done are all registered; each value is driven from the state/counter of the previous cycle.
- States and per-cycle content (t = phase counter, k = kij counter):
  - IDLE: start -> W_L0, k=0. start while busy is ignored.
  - W_L0: col cycles. CEN_wmem=0, WEN_wmem=1, A_wmem=k*col+t. l0_wr=1, delayed one cycle to match SRAM read latency, so l0_wr is active for cycles 1..col.
  - W_LOAD: row+col-1 cycles. l0_rd=1, load=1.
  - GAP: gap cycles. IDLE word.
  - X_STREAM: len_nij cycles. CEN_xmem=0, WEN_xmem=1, A_xmem=t. l0_wr follows one cycle later. l0_rd=1 and execute=1 from t>=1.
  - DRAIN: row+col-1 cycles. l0_rd=1, execute=1.
  - OFIFO_RD: len_nij accepted cycles.
    - Accept when ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=k*len_nij+t, t increments.
    - If ofifo_valid=0: stall. Drive the IDLE word and hold t. This also applies on entry and mid-phase.
    - At t==len_nij: if k<len_kij-1, k++ and go to W_L0; else go to ACC.
  - ACC: per output o (orow=o/o_w, ocol=o%o_w), 11 cycles:
    - j=0..8: CEN_pmem=0, WEN_pmem=1, A_pmem = j*len_nij + (orow+j/k_w)*in_w + ocol + j%k_w. acc=1 for j>=1.
    - j=9: CEN_pmem=1, acc=1.
    - j=10: acc=0. onij_done=1, onij_idx=o.
    - After o=len_onij-1: go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Cycle count without stalls: 9*(8+15+10+36+15+36) + 16*11 = 1256 cycles from first non-idle inst to done.
- Addresses are zero-extended to addr_w. All arithmetic is unsigned and must never exceed (len_kij)*len_nij-1 = 323.
- reset at any time: state returns to IDLE, counters clear, and inst becomes the IDLE word on the next edge.

Decomposition:
- Shared package core_inst_pkg: inst bit-index/field-range constants, IDLE_INST constant, state enum.
- Sub-module acc_addr_gen: counters o, j plus the psum address arithmetic (orow/ocol/j decomposition). Keeps the main FSM clean.

Test Plan:
- reset held 5 cycles, then released with start=0 -> inst stays IDLE word, busy=0.
- start, ofifo_valid tied 1 -> done exactly 1256 cycles after first non-idle inst. W_L0 k=0 shows A_wmem 0..7. k=3 shows A_wmem 24..31.
- ofifo_valid=0 for 5 cycles at OFIFO_RD entry of k=2 -> 5 stall cycles with ofifo_rd=0, CEN_pmem=1. A_pmem writes 72..107 contiguous. done is delayed by 5.
- ACC check -> o=0: A_pmem 0,37,74,114,151,188,228,265,302. o=5, j=4: A_pmem=158. acc high on j=1..9 only.
- start pulsed again while busy -> no effect. Exactly one done pulse; 16 onij_done pulses with idx 0..15.
- reset asserted mid X_STREAM -> next cycle inst = IDLE word, busy=0. A new start restarts from k=0, A_wmem=0.
